mem_access_ctrl: RTL and testbench

Sequences MEM-stage data-memory accesses when the data memory is a multi-cycle slave with a req/ack handshake. Sits between the EX/MEM pipeline register outputs and the data memory. Holds the memory request stable until acknowledged and drives a stall that freezes PC, IF/ID, ID/EX and EX/MEM. Also flags misaligned and timed-out accesses.

---
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer for a multi-cycle data memory with a req/ack handshake.
// Holds the request stable until acknowledged and stalls the pipeline while it waits.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        err_align,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [31:0]        r_rdata;
  logic               r_err_align;
  logic               r_err_timeout;

  logic               w_enable;
  logic               w_aligned;
  logic               w_access;
  logic               w_misaligned;
  logic               w_last_wait;
  logic               w_stall;

  assign w_enable     = MemRead | MemWrite;
  assign w_aligned    = (addr[1:0] == 2'b00);
  assign w_access     = w_enable & w_aligned;
  assign w_misaligned = w_enable & ~w_aligned;
  assign w_last_wait  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. An ack in the last allowed WAIT cycle still completes normally.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_access) w_next_state = WAIT;
      WAIT:    if (mem_ack || w_last_wait) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: stall is raised combinationally in the detect cycle so EX/MEM
  // holds the instruction from the very first cycle of the access.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_access;
      WAIT:    w_stall = 1'b1;
      DONE:    w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  // Handshake: mem_req stays high with mem_we/mem_addr/mem_wdata frozen until the
  // memory returns a single-cycle mem_ack; the request drops on the edge that samples
  // the ack (or on timeout), and an ack seen outside WAIT carries no meaning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0000_0000;
      r_mem_wdata   <= 32'h0000_0000;
      r_rdata       <= 32'h0000_0000;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWrite;
            r_mem_addr  <= addr;
            r_mem_wdata <= wdata;
            r_cnt       <= '0;
          end else if (w_misaligned) begin
            r_err_align <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) r_rdata <= mem_rdata;
          end else if (w_last_wait) begin
            r_mem_req     <= 1'b0;
            r_err_timeout <= 1'b1;
            if (!r_mem_we) r_rdata <= 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign rdata       = r_rdata;
  assign err_align   = r_err_align;
  assign err_timeout = r_err_timeout;
  assign stall       = w_stall;
  assign dbg_state   = r_state;

  a_req_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    r_mem_req == (r_state == WAIT));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: drivers push expected access
// outcomes, a negedge monitor pops and compares them as the DUT completes accesses.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int TO    = 4;
  localparam int EXP_W = 115;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, stall, err_align, err_timeout;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .rdata(rdata),
    .err_align(err_align), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      ref_rdata;
  bit               mon_en = 1'b0;
  int               req_run = 0;
  int               stall_run = 0;

  logic        f_kind, f_we, f_to;
  logic [31:0] f_addr, f_wdata, f_rdata;
  logic [7:0]  f_req, f_stall;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_avail(input string name);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: DUT produced an event with no expected entry (t=%0t)", name, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic kind, input logic we,
      input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
      input logic to, input int req_len, input int stall_len);
    return {kind, we, a, d, rd, to, 8'(req_len), 8'(stall_len)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      req_run   = 0;
      stall_run = 0;
    end else begin
      if (mem_req) begin
        check_avail("req_without_txn");
        if (exp_q.size() != 0) begin
          {f_kind, f_we, f_addr, f_wdata, f_rdata, f_to, f_req, f_stall} = exp_q[0];
          check32("mem_we",    mem_we,    f_we);
          check32("mem_addr",  mem_addr,  f_addr);
          check32("mem_wdata", mem_wdata, f_wdata);
        end
      end
      if (!mem_req && req_run > 0) begin
        check_avail("done_without_txn");
        if (exp_q.size() != 0) begin
          {f_kind, f_we, f_addr, f_wdata, f_rdata, f_to, f_req, f_stall} = exp_q.pop_front();
          check32("done_kind",    f_kind,            1'b0);
          check32("req_cycles",   req_run,           32'(f_req));
          check32("stall_cycles", stall_run,         32'(f_stall));
          check32("stall_done",   stall,             1'b0);
          check32("rdata",        rdata,             f_rdata);
          check32("err_timeout",  err_timeout,       f_to);
          check32("err_align_done", err_align,       1'b0);
        end
      end else begin
        check32("err_timeout_spurious", err_timeout, 1'b0);
      end
      if (err_align) begin
        check_avail("align_without_txn");
        if (exp_q.size() != 0) begin
          {f_kind, f_we, f_addr, f_wdata, f_rdata, f_to, f_req, f_stall} = exp_q.pop_front();
          check32("align_kind",  f_kind,    1'b1);
          check32("align_stall", stall_run, 32'd0);
          check32("align_req",   req_run,   32'd0);
        end
      end
      req_run   = mem_req ? req_run + 1 : 0;
      stall_run = stall ? stall_run + 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1ns after a rising edge; returns 1ns after the edge ending the DONE cycle
  // with the enables cleared, so a following call issues back-to-back.
  // k = WAIT cycle carrying the ack (1..TO), 0 = memory never answers.
  task automatic run_access(input bit rd_en, input bit wr_en, input logic [31:0] a,
                            input logic [31:0] d, input int k, input logic [31:0] rv,
                            input bit stray);
    logic [1:0] lo;
    bit         acked;
    int         n;
    lo       = a[1:0];
    MemRead  = rd_en;
    MemWrite = wr_en;
    addr     = a;
    wdata    = d;
    if (lo != 2'b00) begin
      exp_q.push_back(pack_exp(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0));
      @(posedge clk); #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      return;
    end
    acked = (k >= 1 && k <= TO);
    n     = acked ? k : TO;
    if (!wr_en) ref_rdata = acked ? rv : 32'h0;
    exp_q.push_back(pack_exp(1'b0, wr_en, a, d, ref_rdata, !acked, n, n + 1));
    for (int c = 1; c <= n + 1; c++) begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (acked && c == k) begin
        mem_ack   = 1'b1;
        mem_rdata = rv;
      end
      if (c == n + 1 && stray) mem_ack = 1'b1;
    end
    @(posedge clk); #1;
    mem_ack  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      mem_ack   = stray;
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          sel, k;
    bit          rd_en, wr_en;

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; ref_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_mem_req",     mem_req,     1'b0);
    check32("rst_mem_we",      mem_we,      1'b0);
    check32("rst_mem_addr",    mem_addr,    32'h0);
    check32("rst_mem_wdata",   mem_wdata,   32'h0);
    check32("rst_rdata",       rdata,       32'h0);
    check32("rst_err_align",   err_align,   1'b0);
    check32("rst_err_timeout", err_timeout, 1'b0);
    check32("rst_stall",       stall,       1'b0);
    check32("rst_state",       dbg_state,   2'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2, 1'b0);

    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1234_5678, 1'b0);
    idle_cycles(1, 1'b0);
    run_access(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, TO, 32'hDEAD_BEEF, 1'b0);
    idle_cycles(1, 1'b1);
    run_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h0, 1'b0);
    idle_cycles(1, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0, 1'b0);
    idle_cycles(1, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hA5A5_0010, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1, 32'h5A5A_0014, 1'b0);
    idle_cycles(1, 1'b0);

    // reset in the middle of WAIT discards the access; it is re-issued afterwards
    mon_en   = 1'b0;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    addr     = 32'h0000_0040;
    @(posedge clk); #1;
    check32("rstw_req_wait1", mem_req, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check32("rstw_req_drop", mem_req,   1'b0);
    check32("rstw_state",    dbg_state, 2'd0);
    check32("rstw_rdata",    rdata,     32'h0);
    ref_rdata = 32'h0;
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, 32'h0BAD_F00D, 1'b0);
    idle_cycles(1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      a[1:0] = 2'b00;
      rd_en = (sel <= 3) || (sel == 7);
      wr_en = (sel >= 4 && sel <= 7);
      if (sel >= 8) begin
        a[1:0] = 2'($urandom_range(1, 3));
        rd_en  = 1'($urandom_range(0, 1));
        wr_en  = !rd_en || 1'($urandom_range(0, 1));
      end
      k = $urandom_range(1, TO + 2);
      if (k > TO) k = 0;
      run_access(rd_en, wr_en, a, $urandom, k, $urandom, ($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    idle_cycles(4, 1'b0);
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
